// File: rtl/power_seq_ctrl.sv
// Per-domain power sequencer: OFF -> PWR_UP -> RESTORE -> ON -> ISOLATE -> SAVE -> PWR_DN -> OFF,
// with a single-grant inrush limiter on power-up and sticky ack-timeout flags.
module power_seq_ctrl #(
    parameter int unsigned NUM_DOM = 2,
    parameter int unsigned TIMEOUT = 16,
    parameter bit          RET_EN  = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_DOM-1:0] pwr_req,
    input  logic [NUM_DOM-1:0] pwr_ack,
    input  logic [NUM_DOM-1:0] err_clr,
    output logic [NUM_DOM-1:0] pwr_en,
    output logic [NUM_DOM-1:0] iso_en,
    output logic [NUM_DOM-1:0] dom_rst,
    output logic [NUM_DOM-1:0] ret_save,
    output logic [NUM_DOM-1:0] ret_restore,
    output logic [NUM_DOM-1:0] dom_on,
    output logic [NUM_DOM-1:0] busy,
    output logic [NUM_DOM-1:0] err
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    typedef logic [CntW-1:0] cnt_t;
    localparam cnt_t CntLast = cnt_t'(TIMEOUT);

    typedef enum logic [2:0] {
        StOff,
        StPwrUp,
        StRestore,
        StOn,
        StIsolate,
        StSave,
        StPwrDn
    } state_e;

    state_e             state_q [NUM_DOM];
    state_e             state_d [NUM_DOM];
    cnt_t               cnt_q   [NUM_DOM];
    cnt_t               cnt_d   [NUM_DOM];
    cnt_t               cnt_inc [NUM_DOM];
    logic [NUM_DOM-1:0] timeout;
    logic [NUM_DOM-1:0] set_err;
    logic [NUM_DOM-1:0] saved_q, saved_d;
    logic [NUM_DOM-1:0] err_q, err_d;
    logic [NUM_DOM-1:0] grant;
    logic               up_active;
    logic               grant_taken;

    logic [NUM_DOM-1:0] pwr_en_q, pwr_en_d;
    logic [NUM_DOM-1:0] iso_en_q, iso_en_d;
    logic [NUM_DOM-1:0] dom_rst_q, dom_rst_d;
    logic [NUM_DOM-1:0] ret_save_q, ret_save_d;
    logic [NUM_DOM-1:0] ret_restore_q, ret_restore_d;
    logic [NUM_DOM-1:0] dom_on_q, dom_on_d;
    logic [NUM_DOM-1:0] busy_q, busy_d;

    // Inrush limiter: only one domain may ramp at a time; lowest index wins.
    always_comb begin
        up_active = 1'b0;
        for (int i = 0; i < NUM_DOM; i++) begin
            if (state_q[i] == StPwrUp) begin
                up_active = 1'b1;
            end
        end
    end

    always_comb begin
        grant       = '0;
        grant_taken = up_active;
        for (int i = 0; i < NUM_DOM; i++) begin
            if (!grant_taken && (state_q[i] == StOff) && pwr_req[i]) begin
                grant[i]    = 1'b1;
                grant_taken = 1'b1;
            end
        end
    end

    // Saturating wait counter; timeout fires on the TIMEOUT-th cycle spent waiting.
    always_comb begin
        for (int i = 0; i < NUM_DOM; i++) begin
            cnt_inc[i] = (cnt_q[i] == CntLast) ? CntLast : cnt_q[i] + 1'b1;
            timeout[i] = (cnt_inc[i] == CntLast);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_DOM; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = '0;
            set_err[i] = 1'b0;
            unique case (state_q[i])
                StOff: begin
                    if (grant[i]) begin
                        state_d[i] = StPwrUp;
                    end
                end
                StPwrUp: begin
                    if (pwr_ack[i]) begin
                        state_d[i] = StRestore;
                    end else if (timeout[i]) begin
                        state_d[i] = StOff;
                        set_err[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_inc[i];
                    end
                end
                StRestore: state_d[i] = StOn;
                StOn: begin
                    if (!pwr_req[i]) begin
                        state_d[i] = StIsolate;
                    end
                end
                StIsolate: state_d[i] = StSave;
                StSave:    state_d[i] = StPwrDn;
                StPwrDn: begin
                    if (!pwr_ack[i]) begin
                        state_d[i] = StOff;
                    end else if (timeout[i]) begin
                        state_d[i] = StOff;
                        set_err[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_inc[i];
                    end
                end
                default: state_d[i] = StOff;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_DOM; i++) begin
            saved_d[i] = saved_q[i] | (state_q[i] == StSave);
            if (set_err[i]) begin
                err_d[i] = 1'b1;
            end else if (err_clr[i]) begin
                err_d[i] = 1'b0;
            end else begin
                err_d[i] = err_q[i];
            end
        end
    end

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    always_comb begin
        for (int i = 0; i < NUM_DOM; i++) begin
            pwr_en_d[i]      = 1'b0;
            iso_en_d[i]      = 1'b1;
            dom_rst_d[i]     = 1'b1;
            ret_save_d[i]    = 1'b0;
            ret_restore_d[i] = 1'b0;
            dom_on_d[i]      = 1'b0;
            busy_d[i]        = 1'b1;
            unique case (state_d[i])
                StOff: begin
                    busy_d[i] = 1'b0;
                end
                StPwrUp: begin
                    pwr_en_d[i] = 1'b1;
                end
                StRestore: begin
                    pwr_en_d[i]      = 1'b1;
                    dom_rst_d[i]     = 1'b0;
                    ret_restore_d[i] = RET_EN && saved_d[i];
                end
                StOn: begin
                    pwr_en_d[i]  = 1'b1;
                    iso_en_d[i]  = 1'b0;
                    dom_rst_d[i] = 1'b0;
                    dom_on_d[i]  = 1'b1;
                    busy_d[i]    = 1'b0;
                end
                StIsolate: begin
                    pwr_en_d[i]  = 1'b1;
                    dom_rst_d[i] = 1'b0;
                end
                StSave: begin
                    pwr_en_d[i]   = 1'b1;
                    dom_rst_d[i]  = 1'b0;
                    ret_save_d[i] = RET_EN;
                end
                StPwrDn: begin
                    pwr_en_d[i] = 1'b0;
                end
                default: begin
                    busy_d[i] = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DOM; i++) begin
                state_q[i] <= StOff;
                cnt_q[i]   <= '0;
            end
            saved_q       <= '0;
            err_q         <= '0;
            pwr_en_q      <= '0;
            iso_en_q      <= '1;
            dom_rst_q     <= '1;
            ret_save_q    <= '0;
            ret_restore_q <= '0;
            dom_on_q      <= '0;
            busy_q        <= '0;
        end else begin
            for (int i = 0; i < NUM_DOM; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            saved_q       <= saved_d;
            err_q         <= err_d;
            pwr_en_q      <= pwr_en_d;
            iso_en_q      <= iso_en_d;
            dom_rst_q     <= dom_rst_d;
            ret_save_q    <= ret_save_d;
            ret_restore_q <= ret_restore_d;
            dom_on_q      <= dom_on_d;
            busy_q        <= busy_d;
        end
    end

    assign pwr_en      = pwr_en_q;
    assign iso_en      = iso_en_q;
    assign dom_rst     = dom_rst_q;
    assign ret_save    = ret_save_q;
    assign ret_restore = ret_restore_q;
    assign dom_on      = dom_on_q;
    assign busy        = busy_q;
    assign err         = err_q;

endmodule

// File: tb/tb_power_seq_ctrl.sv
// Bench for power_seq_ctrl: directed sequences plus randomized traffic, all outputs compared
// every cycle against a phase/dwell reference model.
module tb_power_seq_ctrl;

    localparam int ND = 2;
    localparam int TO = 16;

    // Phase codes of the reference model.
    localparam int POff = 0, PUp = 1, PRes = 2, POn = 3, PIso = 4, PSav = 5, PDn = 6;

    logic          clk;
    logic          rst;
    logic [ND-1:0] pwr_req, pwr_ack, err_clr;
    logic [ND-1:0] pwr_en, iso_en, dom_rst, ret_save, ret_restore, dom_on, busy, err;

    int  ph [ND];
    int  dw [ND];
    bit  sv [ND];
    bit  er [ND];
    logic [6:0] pe_tab, iso_tab, drst_tab;

    int  vectors;
    int  miscompares;
    int  up_cyc;
    logic [ND-1:0] stuck;
    logic exp_pe;

    power_seq_ctrl #(
        .NUM_DOM(ND),
        .TIMEOUT(TO),
        .RET_EN (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pwr_req    (pwr_req),
        .pwr_ack    (pwr_ack),
        .err_clr    (err_clr),
        .pwr_en     (pwr_en),
        .iso_en     (iso_en),
        .dom_rst    (dom_rst),
        .ret_save   (ret_save),
        .ret_restore(ret_restore),
        .dom_on     (dom_on),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model one clock using the inputs the DUT samples on the same edge.
    task automatic model_step();
        int  winner;
        bit  up_busy;
        bit  done;
        bit  timed_out;
        if (rst) begin
            for (int i = 0; i < ND; i++) begin
                ph[i] = POff; dw[i] = 0; sv[i] = 0; er[i] = 0;
            end
            return;
        end
        up_busy = 0;
        for (int i = 0; i < ND; i++) if (ph[i] == PUp) up_busy = 1;
        winner = -1;
        if (!up_busy) begin
            for (int i = 0; i < ND; i++) begin
                if (ph[i] == POff && pwr_req[i]) begin
                    winner = i;
                    break;
                end
            end
        end
        for (int i = 0; i < ND; i++) begin
            timed_out = 0;
            case (ph[i])
                POff: if (i == winner) begin ph[i] = PUp; dw[i] = 0; end
                PUp, PDn: begin
                    done = (ph[i] == PUp) ? pwr_ack[i] : !pwr_ack[i];
                    if (done) ph[i] = (ph[i] == PUp) ? PRes : POff;
                    else if (dw[i] + 1 >= TO) begin ph[i] = POff; timed_out = 1; end
                    else dw[i] = dw[i] + 1;
                end
                PRes: ph[i] = POn;
                POn:  if (!pwr_req[i]) ph[i] = PIso;
                PIso: ph[i] = PSav;
                PSav: begin ph[i] = PDn; sv[i] = 1; dw[i] = 0; end
                default: ph[i] = POff;
            endcase
            if (timed_out) er[i] = 1;
            else if (err_clr[i]) er[i] = 0;
        end
    endtask

    task automatic check_all();
        logic [ND-1:0] e_pe, e_iso, e_rst, e_rs, e_rr, e_on, e_busy, e_err;
        for (int i = 0; i < ND; i++) begin
            e_pe[i]   = pe_tab[ph[i]];
            e_iso[i]  = iso_tab[ph[i]];
            e_rst[i]  = drst_tab[ph[i]];
            e_rs[i]   = (ph[i] == PSav);
            e_rr[i]   = (ph[i] == PRes) && sv[i];
            e_on[i]   = (ph[i] == POn);
            e_busy[i] = (ph[i] != POff) && (ph[i] != POn);
            e_err[i]  = er[i];
        end
        chk("pwr_en", 8'(pwr_en), 8'(e_pe));
        chk("iso_en", 8'(iso_en), 8'(e_iso));
        chk("dom_rst", 8'(dom_rst), 8'(e_rst));
        chk("ret_save", 8'(ret_save), 8'(e_rs));
        chk("ret_restore", 8'(ret_restore), 8'(e_rr));
        chk("dom_on", 8'(dom_on), 8'(e_on));
        chk("busy", 8'(busy), 8'(e_busy));
        chk("err", 8'(err), 8'(e_err));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        pe_tab      = 7'b0111110;
        iso_tab     = 7'b1110111;
        drst_tab    = 7'b1000011;
        stuck       = '0;
        rst = 1'b1; pwr_req = '0; pwr_ack = '0; err_clr = '0;
        tick();
        tick();
        chk("reset_pwr_en", 8'(pwr_en), 8'h0);
        chk("reset_iso_en", 8'(iso_en), 8'h3);
        chk("reset_dom_rst", 8'(dom_rst), 8'h3);
        chk("reset_busy", 8'(busy), 8'h0);
        rst = 1'b0;

        // Power-up with ack rising three cycles after pwr_en
        pwr_req = 2'b01;
        tick();
        up_cyc = 0;
        for (int k = 0; k < 4; k++) begin
            if (pwr_en[0] && dom_rst[0]) up_cyc++;
            if (k == 3) pwr_ack[0] = 1'b1;
            tick();
        end
        chk("up_cycles", 8'(up_cyc), 8'd4);
        chk("restore_no_ret", 8'(ret_restore), 8'h0);
        chk("restore_dom_rst", 8'(dom_rst), 8'h2);
        tick();
        chk("on_dom_on", 8'(dom_on), 8'h1);
        chk("on_iso_en", 8'(iso_en), 8'h2);

        // Power-down, then power back up with retention restore
        pwr_req = 2'b00;
        tick();
        chk("iso_iso_en", 8'(iso_en), 8'h3);
        chk("iso_no_save", 8'(ret_save), 8'h0);
        tick();
        chk("save_pulse", 8'(ret_save), 8'h1);
        chk("save_pwr_en", 8'(pwr_en), 8'h1);
        tick();
        chk("dn_pwr_en", 8'(pwr_en), 8'h0);
        chk("dn_save_done", 8'(ret_save), 8'h0);
        tick();
        pwr_ack[0] = 1'b0;
        tick();
        chk("dn_off_busy", 8'(busy), 8'h0);
        pwr_req = 2'b01;
        tick();
        pwr_ack[0] = 1'b1;
        tick();
        chk("restore_pulse", 8'(ret_restore), 8'h1);
        tick();
        chk("restore_once", 8'(ret_restore), 8'h0);
        chk("reup_dom_on", 8'(dom_on), 8'h1);

        // Simultaneous requests: domain 1 waits for domain 0 to leave PWR_UP
        rst = 1'b1; pwr_req = '0; pwr_ack = '0;
        tick();
        rst = 1'b0; pwr_req = 2'b11;
        tick();
        chk("arb_first", 8'(pwr_en), 8'h1);
        pwr_ack = 2'b01;
        tick();
        chk("arb_hold", 8'(pwr_en), 8'h1);
        tick();
        chk("arb_second", 8'(pwr_en), 8'h3);
        chk("arb_busy", 8'(busy), 8'h2);
        pwr_ack = 2'b11;
        tick();
        tick();
        chk("arb_both_on", 8'(dom_on), 8'h3);

        // Request dropped mid power-up: sequence completes, then power-down begins
        rst = 1'b1; pwr_req = '0; pwr_ack = '0;
        tick();
        rst = 1'b0; pwr_req = 2'b01;
        tick();
        pwr_req = 2'b00;
        tick();
        tick();
        chk("drop_still_up", 8'(busy), 8'h1);
        pwr_ack = 2'b01;
        tick();
        tick();
        chk("drop_reaches_on", 8'(dom_on), 8'h1);
        tick();
        chk("drop_isolates", 8'(iso_en), 8'h3);

        // Power-up timeout and err clear
        rst = 1'b1; pwr_req = '0; pwr_ack = '0;
        tick();
        rst = 1'b0; pwr_req = 2'b01;
        tick();
        for (int k = 1; k < TO; k++) tick();
        chk("to_still_up", 8'(busy), 8'h1);
        pwr_req = 2'b00;
        tick();
        chk("to_err", 8'(err), 8'h1);
        chk("to_off", 8'(pwr_en), 8'h0);
        err_clr = 2'b01;
        tick();
        err_clr = 2'b00;
        chk("to_err_clr", 8'(err), 8'h0);

        // Reset during SAVE clears the saved flag
        pwr_req = 2'b01; pwr_ack = 2'b01;
        tick(); tick(); tick();
        pwr_req = 2'b00;
        tick();
        tick();
        chk("rs_in_save", 8'(ret_save), 8'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rs_pwr_en", 8'(pwr_en), 8'h0);
        chk("rs_iso_en", 8'(iso_en), 8'h3);
        chk("rs_dom_rst", 8'(dom_rst), 8'h3);
        pwr_req = 2'b01;
        tick();
        tick();
        chk("rs_saved_cleared", 8'(ret_restore), 8'h0);

        // Randomized traffic, occasionally with a stuck ack to force timeouts
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < ND; i++) begin
                if ($urandom_range(99) == 0) stuck[i] = ~stuck[i];
                if ($urandom_range(7) == 0) pwr_req[i] = ~pwr_req[i];
                exp_pe = pe_tab[ph[i]];
                if (stuck[i]) pwr_ack[i] = ~exp_pe;
                else if ($urandom_range(3) == 0) pwr_ack[i] = 1'($urandom_range(1));
                else pwr_ack[i] = exp_pe;
                err_clr[i] = ($urandom_range(15) == 0);
            end
            rst = ($urandom_range(299) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/power_seq_ctrl.md
POWER_SEQ_CTRL -- requirements
Module: power_seq_ctrl

Interface
REQ-001 Parameter NUM_DOM, default 2, number of switchable power domains (1..8).
REQ-002 Parameter TIMEOUT, default 16, max cycles to wait for pwr_ack in PWR_UP/PWR_DN (2..255).
REQ-003 Parameter RET_EN, default 1; 0 = ret_save/ret_restore held 0, but SAVE/RESTORE states still traversed.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 pwr_req  input  NUM_DOM  per domain: 1 = request ON, 0 = request OFF.
REQ-007 pwr_ack  input  NUM_DOM  per-domain power-switch feedback, 1 = rail up.
REQ-008 err_clr  input  NUM_DOM  per-domain clear of sticky err.
REQ-009 pwr_en  output  NUM_DOM  power-switch enable.
REQ-010 iso_en  output  NUM_DOM  isolation enable, 1 = outputs clamped.
REQ-011 dom_rst  output  NUM_DOM  reset to gated domain, 1 = held in reset.
REQ-012 ret_save  output  NUM_DOM  one-cycle retention save pulse.
REQ-013 ret_restore  output  NUM_DOM  one-cycle retention restore pulse.
REQ-014 dom_on  output  NUM_DOM  1 = domain in ON state.
REQ-015 busy  output  NUM_DOM  1 = domain mid-sequence (not OFF, not ON).
REQ-016 err  output  NUM_DOM  sticky ack-timeout flag.

Function
REQ-017 Each domain SHALL have an independent FSM: OFF, PWR_UP, RESTORE, ON, ISOLATE, SAVE, PWR_DN; all outputs registered Moore decodes of state/flags.
REQ-018 Per-state outputs (pwr_en/iso_en/dom_rst): OFF 0/1/1; PWR_UP 1/1/1; RESTORE 1/1/0; ON 1/0/0; ISOLATE 1/1/0; SAVE 1/1/0; PWR_DN 0/1/1.
REQ-019 OFF -> PWR_UP when pwr_req=1 and domain holds the power-up grant (REQ-026).
REQ-020 PWR_UP: per-domain counter increments from 0 each cycle; pwr_ack=1 -> RESTORE; counter reaching TIMEOUT with pwr_ack=0 -> OFF and err=1.
REQ-021 RESTORE lasts exactly 1 cycle, then ON; ret_restore=1 only if RET_EN=1 and the domain's saved flag=1.
REQ-022 ON -> ISOLATE when pwr_req=0; ISOLATE lasts 1 cycle, then SAVE.
REQ-023 SAVE lasts 1 cycle, then PWR_DN; ret_save=1 if RET_EN=1; saved flag set.
REQ-024 PWR_DN: counter restarts at 0; pwr_ack=0 -> OFF; timeout -> OFF and err=1 (pwr_en stays 0).
REQ-025 pwr_req SHALL be sampled only in OFF and ON; changes during any other state are ignored until that state's sequence completes, then re-evaluated.
REQ-026 Inrush limit: at most one domain in PWR_UP at any time; OFF->PWR_UP granted only when no domain is in PWR_UP, lowest index wins among simultaneous requesters; losers stay OFF.
REQ-027 Power-down sequences SHALL NOT be arbitrated; any number of domains may be in ISOLATE/SAVE/PWR_DN concurrently.
REQ-028 err set has priority over err_clr in the same cycle; otherwise err_clr=1 clears err next cycle; err does not block sequencing.
REQ-029 Counter width = $clog2(TIMEOUT+1); counter SHALL NOT wrap; pwr_ack asserted on the timeout cycle counts as success.
REQ-030 dom_on=1 iff state ON; busy=1 iff state not in {OFF, ON}.

Reset
REQ-031 rst=1 SHALL force every domain to OFF within one clock, regardless of current state, including mid-sequence.
REQ-032 Reset values: pwr_en=0, iso_en=all 1, dom_rst=all 1, ret_save=0, ret_restore=0, dom_on=0, busy=0, err=0, saved flags=0, counters=0.

Verification
REQ-033 NUM_DOM=2: pwr_req=01, pwr_ack[0] rises 3 cycles after pwr_en[0] -> PWR_UP 4 cycles, 1 RESTORE cycle with ret_restore=0 (never saved), then dom_on[0]=1, iso_en[0]=0.
REQ-034 Domain 0 ON, pwr_req[0] 1->0, ack falls 2 cycles after pwr_en drop -> iso_en=1 before ret_save pulse (1 cycle), pwr_en=0 after save, OFF reached; following power-up gives ret_restore=1 for 1 cycle.
REQ-035 pwr_req=11 in same cycle from OFF -> domain 0 enters PWR_UP first; domain 1 enters PWR_UP only in the cycle after domain 0 leaves PWR_UP.
REQ-036 TIMEOUT=16, pwr_ack held 0 -> after 16 PWR_UP cycles, domain returns OFF, err=1; err_clr pulse -> err=0 next cycle.
REQ-037 rst asserted while domain in SAVE -> next cycle OFF, pwr_en=0, iso_en=1, dom_rst=1, saved flag=0.
REQ-038 pwr_req toggled 1->0 during PWR_UP -> sequence completes to ON, then ISOLATE begins next cycle.
